// File: rtl/baud_generator_frac.sv
// Fractional baud tick generator: programmable int.frac divisor,
// oversampled rx_tick and derived tx_tick, glitch-free divisor updates.
module baud_generator_frac #(
  parameter int INT_W          = 16,
  parameter int FRAC_W         = 4,
  parameter int OVERSAMPLE     = 16,
  parameter int RESET_DIV_INT  = 325,
  parameter int RESET_DIV_FRAC = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          baud_gen_en,
  input  logic                          sync_clr,
  input  logic [INT_W-1:0]              div_int,
  input  logic [FRAC_W-1:0]             div_frac,
  input  logic                          div_load,
  output logic                          div_pending,
  output logic                          rx_tick,
  output logic                          tx_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_index
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [INT_W-1:0] RST_INT = INT_W'(RESET_DIV_INT);
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(RESET_DIV_FRAC);

  logic [INT_W:0]    cnt;
  logic [FRAC_W-1:0] acc;
  logic              ext;
  logic [INT_W-1:0]  act_int;
  logic [INT_W-1:0]  sh_int;
  logic [FRAC_W-1:0] act_frac;
  logic [FRAC_W-1:0] sh_frac;
  logic [INT_W:0]    eff_int;
  logic [INT_W:0]    period;
  logic              wrap;
  logic [FRAC_W-1:0] nxt_frac;
  logic [FRAC_W:0]   sum;

  // Divisors below 2 are clamped; the extend bit stretches a period by one.
  assign eff_int  = (act_int < INT_W'(2)) ? (INT_W+1)'(2)
                                          : {1'b0, act_int};
  assign period   = eff_int + {{INT_W{1'b0}}, ext};
  assign wrap     = baud_gen_en && (cnt == period - (INT_W+1)'(1));
  assign nxt_frac = div_pending ? sh_frac : act_frac;
  assign sum      = {1'b0, acc} + {1'b0, nxt_frac};

  // Shadow capture and hand-over of the divisor at tick boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_int     <= RST_INT;
      act_frac    <= RST_FRAC;
      sh_int      <= RST_INT;
      sh_frac     <= RST_FRAC;
      div_pending <= 1'b0;
    end else if (sync_clr) begin
      if (div_load) begin
        act_int  <= div_int;
        act_frac <= div_frac;
        sh_int   <= div_int;
        sh_frac  <= div_frac;
      end else if (div_pending) begin
        act_int  <= sh_int;
        act_frac <= sh_frac;
      end
      div_pending <= 1'b0;
    end else begin
      if (wrap && div_pending) begin
        act_int  <= sh_int;
        act_frac <= sh_frac;
      end
      if (div_load) begin
        sh_int      <= div_int;
        sh_frac     <= div_frac;
        div_pending <= 1'b1;
      end else if (wrap) begin
        div_pending <= 1'b0;
      end
    end
  end

  // Period counter, fractional accumulator and oversample phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      ext      <= 1'b0;
      os_index <= '0;
    end else if (sync_clr) begin
      cnt      <= '0;
      acc      <= '0;
      ext      <= 1'b0;
      os_index <= '0;
    end else if (baud_gen_en) begin
      if (wrap) begin
        cnt      <= '0;
        acc      <= sum[FRAC_W-1:0];
        ext      <= sum[FRAC_W];
        os_index <= os_index + OS_W'(1);
      end else begin
        cnt <= cnt + (INT_W+1)'(1);
      end
    end
  end

  // Registered one-cycle tick pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_tick <= 1'b0;
      tx_tick <= 1'b0;
    end else begin
      rx_tick <= !sync_clr && wrap;
      tx_tick <= !sync_clr && wrap && (os_index == OS_LAST);
    end
  end

endmodule

// File: tb/tb_baud_generator_frac.sv
// Directed self-checking bench for baud_generator_frac
// (OVERSAMPLE=4, default 16.4 divisor widths).
module tb_baud_generator_frac;

  logic        clk = 1'b0;
  logic        rst;
  logic        baud_gen_en;
  logic        sync_clr;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        div_load;
  logic        div_pending;
  logic        rx_tick;
  logic        tx_tick;
  logic [1:0]  os_index;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int c0       = 0;
  int bad_tx   = 0;
  int rx_q[$];
  int tx_q[$];
  int os_q[$];

  baud_generator_frac #(
    .OVERSAMPLE(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_gen_en(baud_gen_en),
    .sync_clr   (sync_clr),
    .div_int    (div_int),
    .div_frac   (div_frac),
    .div_load   (div_load),
    .div_pending(div_pending),
    .rx_tick    (rx_tick),
    .tx_tick    (tx_tick),
    .os_index   (os_index)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_tick) begin
      rx_q.push_back(cyc);
      os_q.push_back(int'(os_index));
    end
    if (tx_tick) tx_q.push_back(cyc);
    if (tx_tick && !rx_tick) bad_tx++;
  end

  task automatic check(string tag, longint got, longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic upto(int k);
    while (cyc - c0 < k) @(negedge clk);
  endtask

  task automatic start();
    baud_gen_en = 1'b1;
    c0 = cyc;
    rx_q.delete();
    tx_q.delete();
    os_q.delete();
  endtask

  task automatic cfg(int vi, int vf);
    baud_gen_en = 1'b0;
    step(1);
    div_int  = 16'(vi);
    div_frac = 4'(vf);
    div_load = 1'b1;
    sync_clr = 1'b1;
    step(1);
    div_load = 1'b0;
    sync_clr = 1'b0;
    step(1);
  endtask

  task automatic load_at(int k, int vi, int vf);
    upto(k - 1);
    div_int  = 16'(vi);
    div_frac = 4'(vf);
    div_load = 1'b1;
    step(1);
    div_load = 1'b0;
  endtask

  task automatic first(string tag, int exp);
    check(tag, (rx_q.size() > 0) ? rx_q[0] - c0 : -1, exp);
  endtask

  task automatic gap(string tag, int i, int exp);
    check(tag, (rx_q.size() > i + 1) ? rx_q[i+1] - rx_q[i] : -1, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    int exp_gap[4];
    rst         = 1'b1;
    baud_gen_en = 1'b0;
    sync_clr    = 1'b0;
    div_int     = '0;
    div_frac    = '0;
    div_load    = 1'b0;
    step(2);
    check("rst_rx", rx_tick, 0);
    check("rst_tx", tx_tick, 0);
    check("rst_pend", div_pending, 0);
    check("rst_os", os_index, 0);
    rst = 1'b0;
    step(1);

    // int=4 frac=0, OVERSAMPLE=4
    div_int  = 16'd4;
    div_frac = 4'd0;
    div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    check("t1_pend_set", div_pending, 1);
    sync_clr = 1'b1;
    step(1);
    sync_clr = 1'b0;
    check("t1_pend_clr", div_pending, 0);
    start();
    upto(41);
    first("t1_first", 4);
    gap("t1_gap0", 0, 4);
    gap("t1_gap5", 5, 4);
    check("t1_nrx", rx_q.size(), 10);
    check("t1_ntx", tx_q.size(), 2);
    check("t1_tx0", (tx_q.size() > 0) ? tx_q[0] - c0 : -1, 16);
    check("t1_txgap", (tx_q.size() > 1) ? tx_q[1] - tx_q[0] : -1, 16);
    check("t1_tx_coinc", bad_tx, 0);
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (os_q.size() <= i || os_q[i] != (i + 1) % 4) bad++;
    check("t1_os_seq", bad, 0);

    // int=4 frac=8 -> 4,4,5,4,5...
    cfg(4, 8);
    check("t2_pend", div_pending, 0);
    start();
    upto(150);
    first("t2_first", 4);
    exp_gap = '{4, 5, 4, 5};
    for (int i = 0; i < 4; i++) gap($sformatf("t2_gap%0d", i), i, exp_gap[i]);
    check("t2_sum32", (rx_q.size() > 32) ? rx_q[32] - rx_q[0] : -1, 144);

    // mid-period change 10 -> 6
    cfg(10, 0);
    start();
    load_at(4, 6, 0);
    check("t3_pend_a", div_pending, 1);
    upto(9);
    check("t3_pend_b", div_pending, 1);
    check("t3_rx_b", rx_tick, 0);
    upto(10);
    check("t3_pend_c", div_pending, 0);
    check("t3_rx_c", rx_tick, 1);
    upto(24);
    first("t3_first", 10);
    gap("t3_gap0", 0, 6);
    gap("t3_gap1", 1, 6);

    // two loads then load at wrap
    cfg(10, 0);
    start();
    load_at(2, 8, 0);
    load_at(4, 12, 0);
    load_at(16, 7, 0);
    load_at(22, 5, 0);
    check("t4_pend_wrap", div_pending, 1);
    check("t4_rx_wrap", rx_tick, 1);
    upto(28);
    check("t4_pend_hold", div_pending, 1);
    upto(29);
    check("t4_pend_drop", div_pending, 0);
    upto(41);
    first("t4_first", 10);
    gap("t4_gap0", 0, 12);
    gap("t4_gap1", 1, 7);
    gap("t4_gap2", 2, 5);
    gap("t4_gap3", 3, 5);

    // enable gap
    cfg(5, 0);
    start();
    upto(2);
    baud_gen_en = 1'b0;
    step(7);
    check("t5_quiet", rx_q.size() + tx_q.size(), 0);
    baud_gen_en = 1'b1;
    c0 = cyc;
    upto(4);
    first("t5_resume", 3);

    // clamp
    cfg(0, 0);
    start();
    upto(9);
    first("t6_int0_first", 2);
    gap("t6_int0_gap0", 0, 2);
    gap("t6_int0_gap1", 1, 2);
    cfg(1, 0);
    start();
    upto(9);
    first("t6_int1_first", 2);
    gap("t6_int1_gap", 1, 2);

    // async reset mid-period, pending shadow discarded
    div_int  = 16'd9;
    div_frac = 4'd0;
    div_load = 1'b1;
    step(1);
    div_load = 1'b0;
    check("t7_pend_pre", div_pending, 1);
    for (int i = 0; i < 4 && !rx_tick; i++) step(1);
    #3 rst = 1'b1;
    #1;
    check("t7_rx", rx_tick, 0);
    check("t7_tx", tx_tick, 0);
    check("t7_pend", div_pending, 0);
    check("t7_os", os_index, 0);
    step(2);
    rst = 1'b0;
    start();
    upto(980);
    first("t7_first", 325);
    gap("t7_gap0", 0, 325);
    gap("t7_gap1", 1, 326);
    check("t7_pend_post", div_pending, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
